// File: rtl/fir_input_sequencer.sv
// Sample feeder for the FIR core: buffers a valid/ready stream in a FIFO and issues one
// sample at a time, waiting for the core's outputValid, with a watchdog for a silent core.
module fir_input_sequencer #(
    parameter int InputWidth    = 16,
    parameter int FifoDepth     = 16,
    parameter int AddrWidth     = 4,
    parameter int TimeoutCycles = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [InputWidth-1:0] s_data,
    input  logic                  flush,
    output logic                  inputValid,
    output logic [InputWidth-1:0] FIR_input,
    input  logic                  outputValid,
    output logic                  busy,
    output logic [AddrWidth:0]    fifo_count,
    output logic [31:0]           sample_count,
    output logic                  timeout
);
    localparam int WdogWidth = $clog2(TimeoutCycles);
    localparam logic [WdogWidth-1:0] WdogLast  = WdogWidth'(TimeoutCycles - 1);
    localparam logic [AddrWidth:0]   CountFull = (AddrWidth + 1)'(FifoDepth);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [InputWidth-1:0] mem_q [FifoDepth];
    logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AddrWidth:0]    count_q, count_d;
    logic                  iv_q, iv_d;
    logic [InputWidth-1:0] fir_q, fir_d;
    logic [31:0]           sc_q, sc_d;
    logic                  timeout_q, timeout_d;
    logic [WdogWidth-1:0]  wdog_q, wdog_d;
    logic                  push, pop;

    // Readiness depends only on the registered count, so a same-cycle pop never raises it.
    assign s_ready      = (count_q < CountFull);
    assign inputValid   = iv_q;
    assign FIR_input    = fir_q;
    assign busy         = (state_q == WAIT);
    assign fifo_count   = count_q;
    assign sample_count = sc_q;
    assign timeout      = timeout_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        iv_d      = 1'b0;
        fir_d     = fir_q;
        sc_d      = sc_q;
        timeout_d = timeout_q;
        wdog_d    = wdog_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (flush) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            wdog_d   = '0;
        end else begin
            push = s_valid && s_ready;
            case (state_q)
                IDLE: pop = (count_q != '0);
                WAIT: begin
                    // The core's strobe is not trusted in the cycle the sample is presented.
                    if (outputValid && !iv_q) begin
                        if (count_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (wdog_q == WdogLast) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        wdog_d = wdog_q + WdogWidth'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            if (pop) begin
                fir_d    = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AddrWidth'(1);
                iv_d     = 1'b1;
                sc_d     = sc_q + 32'd1;
                wdog_d   = '0;
                state_d  = WAIT;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AddrWidth'(1);
            end
            count_d = count_q + (AddrWidth + 1)'(push) - (AddrWidth + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            iv_q      <= 1'b0;
            fir_q     <= '0;
            sc_q      <= '0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            iv_q      <= iv_d;
            fir_q     <= fir_d;
            sc_q      <= sc_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
        end
    end
endmodule
